// File: rtl/strobe_gen_mc.sv
// Multi-channel strobe generator: per channel, marker-triggered or free-running one-cycle strobes.
// Latency: marker mode strobes interval+2 cycles after the marker; free-running period is interval+1.
// No backpressure: a marker arriving while a channel is still counting is dropped and flagged in overrun.
`timescale 1ns/1ps

module strobe_gen_mc #(
  parameter int NUM_CH = 4,
  parameter int CNT_W  = 16
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [NUM_CH*CNT_W-1:0] interval,
  input  logic [NUM_CH-1:0]       mode,
  input  logic [NUM_CH-1:0]       user_marker,
  input  logic [NUM_CH-1:0]       online,
  input  logic                    clr_err,
  output logic [NUM_CH-1:0]       user_strobe,
  output logic [NUM_CH-1:0]       overrun
);

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } ch_state_t;

  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  genvar c;
  generate
    for (c = 0; c < NUM_CH; c++) begin : g_ch
      ch_state_t        state_q;
      ch_state_t        state_d;
      logic [CNT_W-1:0] count_q;
      logic [CNT_W-1:0] count_d;
      logic             marker_dly_q;
      logic             overrun_q;
      logic             overrun_d;
      logic [CNT_W-1:0] ival;
      logic             at_zero;
      logic             free_run;
      logic             drop;

      assign ival     = interval[c*CNT_W +: CNT_W];
      assign at_zero  = (count_q == '0);
      assign free_run = mode[c];

      // Marker is registered once so the strobe never depends combinationally on it.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          marker_dly_q <= 1'b0;
        end else begin
          marker_dly_q <= user_marker[c];
        end
      end

      // Channel state and interval counter registers.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          state_q <= ST_IDLE;
          count_q <= '0;
        end else begin
          state_q <= state_d;
          count_q <= count_d;
        end
      end

      // Next-state: load on start, count down, reload or go idle at zero; flag dropped markers.
      always_comb begin
        state_d = state_q;
        count_d = count_q;
        drop    = 1'b0;
        if (!online[c]) begin
          state_d = ST_IDLE;
          count_d = '0;
        end else begin
          case (state_q)
            ST_IDLE: begin
              // Free-running starts unconditionally; marker mode waits for a marker.
              if (free_run || marker_dly_q) begin
                state_d = ST_RUN;
                count_d = ival;
              end
            end
            ST_RUN: begin
              if (!at_zero) begin
                // Never decrement through zero; a marker here cannot be honoured.
                count_d = count_q - CNT_ONE;
                drop    = !free_run && marker_dly_q;
              end else if (free_run || marker_dly_q) begin
                // Strobe cycle: a coincident marker (or free-running) restarts the interval.
                count_d = ival;
              end else begin
                state_d = ST_IDLE;
              end
            end
            default: begin
              state_d = ST_IDLE;
              count_d = '0;
            end
          endcase
        end
      end

      // A new drop takes priority over a clear in the same cycle.
      assign overrun_d = drop ? 1'b1 : (clr_err ? 1'b0 : overrun_q);

      // Sticky overrun flag register.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          overrun_q <= 1'b0;
        end else begin
          overrun_q <= overrun_d;
        end
      end

      assign user_strobe[c] = online[c] && (state_q == ST_RUN) && at_zero;
      assign overrun[c]     = overrun_q;
    end
  endgenerate

endmodule
